// File: rtl/onehot_entry_allocator.sv
// onehot_entry_allocator
//   Free-list allocator handing out one-hot entry vectors for RAMs that are
//   addressed without a decoder (PRF, LSQ, ROB-style tables). A DEPTH-bit
//   free bitmap is tracked; every cycle up to NUM_ALLOC distinct free entries
//   are offered as one-hot vectors, lowest index first. Released entries come
//   back as one-hot vectors and become offerable the cycle after release.
//
// Ports
//   clk           clock
//   reset         asynchronous, active-low reset
//   flush_i       restore bitmap, count and error flag to the post-reset pattern
//   allocReq_i    [NUM_ALLOC]          consume the entry offered on port k
//   allocValid_o  [NUM_ALLOC]          port k offers a free entry
//   allocVec_o    [NUM_ALLOC][DEPTH]   one-hot offered entry (zero when not valid)
//   freeEn_i      [NUM_FREE]           release request on port f
//   freeVec_i     [NUM_FREE][DEPTH]    one-hot entry being released
//   freeCount_o   [CNT_W]              registered number of free entries
//   doubleFree_o                       sticky: an already-free entry was released
module onehot_entry_allocator #(
    parameter int DEPTH     = 32,
    parameter int NUM_ALLOC = 2,
    parameter int NUM_FREE  = 2,
    parameter int RESERVED  = 0,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush_i,
    input  logic [NUM_ALLOC-1:0]              allocReq_i,
    output logic [NUM_ALLOC-1:0]              allocValid_o,
    output logic [NUM_ALLOC-1:0][DEPTH-1:0]   allocVec_o,
    input  logic [NUM_FREE-1:0]               freeEn_i,
    input  logic [NUM_FREE-1:0][DEPTH-1:0]    freeVec_i,
    output logic [CNT_W-1:0]                  freeCount_o,
    output logic                              doubleFree_o
);

    // Entries 0..RESERVED-1 start out allocated.
    localparam logic [DEPTH-1:0] RESET_MAP = {DEPTH{1'b1}} << RESERVED;
    localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(DEPTH - RESERVED);

    logic [DEPTH-1:0] free_map_q, free_map_d;
    logic [CNT_W-1:0] free_count_q, free_count_d;
    logic             double_free_q, double_free_d;

    logic [NUM_ALLOC-1:0][DEPTH-1:0] offer_vec;
    logic [NUM_ALLOC-1:0][DEPTH-1:0] grant_vec;

    function automatic logic [CNT_W-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Offer chain: each port takes the lowest set bit of what the earlier
    // ports left behind. Depends on the registered bitmap only, so the
    // offers never overlap and never see a same-cycle release.
    always_comb begin
        logic [DEPTH-1:0] remaining;
        remaining = free_map_q;
        offer_vec = '0;
        for (int k = 0; k < NUM_ALLOC; k++) begin
            offer_vec[k] = remaining & (~remaining + DEPTH'(1));
            remaining    = remaining & ~offer_vec[k];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ALLOC; gi++) begin : g_port
            assign allocValid_o[gi] = (free_count_q > CNT_W'(gi));
            assign allocVec_o[gi]   = allocValid_o[gi] ? offer_vec[gi] : '0;
            // A request on a port with nothing to offer is silently dropped.
            assign grant_vec[gi]    = (allocReq_i[gi] && allocValid_o[gi]) ? offer_vec[gi] : '0;
        end
    endgenerate

    always_comb begin
        logic [DEPTH-1:0] granted;
        logic [DEPTH-1:0] released;
        logic [DEPTH-1:0] held;
        logic [DEPTH-1:0] newly_set;
        logic             dup;

        granted  = '0;
        released = '0;
        dup      = 1'b0;

        for (int k = 0; k < NUM_ALLOC; k++) begin
            granted = granted | grant_vec[k];
        end

        // A release is a double free if the entry is already free, or if an
        // earlier release port in the same cycle names the same entry.
        for (int f = 0; f < NUM_FREE; f++) begin
            if (freeEn_i[f]) begin
                if (|(freeVec_i[f] & (free_map_q | released))) begin
                    dup = 1'b1;
                end
                released = released | freeVec_i[f];
            end
        end

        held      = free_map_q & ~granted;
        // Only bits that really flip to free are counted, so the count stays
        // equal to the bitmap population even on a double free.
        newly_set = released & ~held;

        free_map_d    = held | released;
        free_count_d  = free_count_q - popcnt(granted) + popcnt(newly_set);
        double_free_d = double_free_q | dup;

        // Flush wins over every grant and release this cycle.
        if (flush_i) begin
            free_map_d    = RESET_MAP;
            free_count_d  = RESET_CNT;
            double_free_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_map_q    <= RESET_MAP;
            free_count_q  <= RESET_CNT;
            double_free_q <= 1'b0;
        end else begin
            free_map_q    <= free_map_d;
            free_count_q  <= free_count_d;
            double_free_q <= double_free_d;
        end
    end

    assign freeCount_o  = free_count_q;
    assign doubleFree_o = double_free_q;

endmodule

// File: tb/tb_onehot_entry_allocator.sv
module tb_onehot_entry_allocator;

    localparam int DEPTH = 32;
    localparam int NA    = 2;
    localparam int NF    = 2;
    localparam int RSV   = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                     clk;
    logic                     reset_n;
    logic                     flush;
    logic [NA-1:0]            req;
    logic [NA-1:0]            valid;
    logic [NA-1:0][DEPTH-1:0] avec;
    logic [NF-1:0]            fen;
    logic [NF-1:0][DEPTH-1:0] fvec;
    logic [CW-1:0]            cnt;
    logic                     dbl;

    onehot_entry_allocator #(
        .DEPTH(DEPTH), .NUM_ALLOC(NA), .NUM_FREE(NF), .RESERVED(RSV)
    ) dut (
        .clk(clk), .reset(reset_n), .flush_i(flush),
        .allocReq_i(req), .allocValid_o(valid), .allocVec_o(avec),
        .freeEn_i(fen), .freeVec_i(fvec),
        .freeCount_o(cnt), .doubleFree_o(dbl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cnt_valid_dummy;
    } unused_t;

    typedef struct {
        logic [5:0]  cnt;
        logic [1:0]  valid;
        logic [31:0] v0;
        logic [31:0] v1;
        logic        dbl;
    } exp_t;

    typedef struct {
        logic        flush;
        logic [1:0]  req;
        logic [1:0]  fen;
        logic [31:0] fv0;
        logic [31:0] fv1;
        exp_t        e;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t reset_exp;
    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".count"}, 32'(cnt),   32'(e.cnt));
        check({tag, ".valid"}, 32'(valid), 32'(e.valid));
        check({tag, ".vec0"},  avec[0],    e.v0);
        check({tag, ".vec1"},  avec[1],    e.v1);
        check({tag, ".dbl"},   32'(dbl),   32'(e.dbl));
    endtask

    task automatic drive(input logic f, input logic [1:0] r, input logic [1:0] en,
                         input logic [31:0] fv0, input logic [31:0] fv1);
        flush   = f;
        req     = r;
        fen     = en;
        fvec[0] = fv0;
        fvec[1] = fv1;
    endtask

    // Advance one edge and pop the oldest expectation against the outputs.
    task automatic tick_and_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got count %0d expected an entry", tag, cnt);
        end else begin
            e = sb_q.pop_front();
            check_outputs(tag, e);
            $display("txn %s: count=%0d valid=%b vec0=0x%08h vec1=0x%08h dbl=%b",
                     tag, cnt, valid, avec[0], avec[1], dbl);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        drive(v.flush, v.req, v.fen, v.fv0, v.fv1);
        sb_q.push_back(v.e);
        tick_and_check(tag);
    endtask

    function automatic exp_t mk(input int c, input logic [1:0] va, input logic [31:0] a,
                                input logic [31:0] b, input logic d);
        exp_t e;
        e.cnt = 6'(c); e.valid = va; e.v0 = a; e.v1 = b; e.dbl = d;
        return e;
    endfunction

    function automatic vec_t mv(input logic f, input logic [1:0] r, input logic [1:0] en,
                                input logic [31:0] fv0, input logic [31:0] fv1, input exp_t e);
        vec_t v;
        v.flush = f; v.req = r; v.fen = en; v.fv0 = fv0; v.fv1 = fv1; v.e = e;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   c;
        logic [31:0] one;

        one       = 32'h1;
        reset_exp = mk(28, 2'b11, 32'h10, 32'h20, 1'b0);

        // Directed table: inputs applied for one cycle, outputs expected after the edge.
        tbl[0]  = mv(0, 2'b01, 2'b01, 32'h4,  32'h0, mk(28, 2'b11, 32'h4,  32'h20,  0)); // grant 4, release 2
        tbl[1]  = mv(0, 2'b11, 2'b00, 32'h0,  32'h0, mk(26, 2'b11, 32'h40, 32'h80,  0)); // grant 2,5
        tbl[2]  = mv(0, 2'b00, 2'b01, 32'h80, 32'h0, mk(26, 2'b11, 32'h40, 32'h80,  1)); // double free 7
        tbl[3]  = mv(0, 2'b00, 2'b00, 32'h0,  32'h0, mk(26, 2'b11, 32'h40, 32'h80,  1)); // sticky
        tbl[4]  = mv(0, 2'b10, 2'b00, 32'h0,  32'h0, mk(25, 2'b11, 32'h40, 32'h100, 1)); // port1 only
        tbl[5]  = mv(1, 2'b11, 2'b01, 32'h1,  32'h0, reset_exp);                          // flush overrides
        tbl[6]  = mv(0, 2'b00, 2'b11, 32'h2,  32'h2, mk(29, 2'b11, 32'h2,  32'h10,  1)); // same entry twice
        tbl[7]  = mv(1, 2'b00, 2'b00, 32'h0,  32'h0, reset_exp);
        tbl[8]  = mv(0, 2'b00, 2'b11, 32'h1,  32'h8, mk(30, 2'b11, 32'h1,  32'h8,   0)); // release 0,3
        tbl[9]  = mv(0, 2'b11, 2'b10, 32'h0,  32'h4, mk(29, 2'b11, 32'h4,  32'h10,  0)); // grant 0,3 + release 2
        tbl[10] = mv(1, 2'b00, 2'b00, 32'h0,  32'h0, reset_exp);

        reset_n = 1'b0;
        drive(0, 2'b00, 2'b00, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_outputs("reset", reset_exp);
        $display("txn reset: count=%0d vec0=0x%08h vec1=0x%08h", cnt, avec[0], avec[1]);

        for (int i = 0; i < 11; i++) begin
            apply($sformatf("tbl%0d", i), tbl[i]);
        end

        // Drain: two entries per cycle, handed out in ascending order.
        for (int i = 1; i <= 14; i++) begin
            c = 28 - 2 * i;
            if (c >= 2)
                v = mv(0, 2'b11, 2'b00, 0, 0, mk(c, 2'b11, one << (4 + 2 * i), one << (5 + 2 * i), 0));
            else
                v = mv(0, 2'b11, 2'b00, 0, 0, mk(0, 2'b00, 32'h0, 32'h0, 0));
            apply($sformatf("drain%0d", i), v);
        end

        // Requests while empty are ignored.
        apply("empty_req", mv(0, 2'b11, 2'b00, 0, 0, mk(0, 2'b00, 0, 0, 0)));

        // Release into an empty list: not offered until the next cycle.
        drive(0, 2'b00, 2'b01, one << 9, 32'h0);
        #1;
        check("same_cycle.valid0", 32'(valid[0]), 32'h0);
        check("same_cycle.vec0", avec[0], 32'h0);
        sb_q.push_back(mk(1, 2'b01, one << 9, 32'h0, 0));
        tick_and_check("release9");

        // Port 1 request with only one entry free is dropped.
        apply("grant9", mv(0, 2'b11, 2'b00, 0, 0, mk(0, 2'b00, 0, 0, 0)));

        // Fill to DEPTH, then any release is a double free.
        apply("flush2",  mv(1, 2'b00, 2'b00, 0, 0, reset_exp));
        apply("rel01",   mv(0, 2'b00, 2'b11, 32'h1, 32'h2, mk(30, 2'b11, 32'h1, 32'h2, 0)));
        apply("rel23",   mv(0, 2'b00, 2'b11, 32'h4, 32'h8, mk(32, 2'b11, 32'h1, 32'h2, 0)));
        apply("full_rel",mv(0, 2'b00, 2'b01, 32'h20, 32'h0, mk(32, 2'b11, 32'h1, 32'h2, 1)));
        apply("flush3",  mv(1, 2'b00, 2'b00, 0, 0, reset_exp));

        // Asynchronous reset between edges while allocating with the error flag set.
        apply("pre_a",   mv(0, 2'b11, 2'b01, 32'h80, 32'h0, mk(26, 2'b11, 32'h40, 32'h80, 1)));
        drive(0, 2'b11, 2'b00, 32'h0, 32'h0);
        #3;
        reset_n = 1'b0;
        #1;
        check_outputs("async_rst", reset_exp);
        $display("txn async_rst: count=%0d vec0=0x%08h dbl=%b", cnt, avec[0], dbl);
        @(posedge clk);
        #1;
        check_outputs("rst_hold", reset_exp);
        reset_n = 1'b1;
        apply("post_rst", mv(0, 2'b00, 2'b00, 0, 0, reset_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
